// File: rtl/match_fifo_sched.sv
// match_fifo_sched: round-robin match-FIFO writer, skid-buffered reader and job sequencer.
// MATCH_SCHED_STATS_EN builds the wr_cnt/rd_cnt statistics counters; otherwise they read 0.
module match_fifo_sched #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              start_compress,
  input  logic              data_terminal,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              fifo_wr_req,
  output logic [DATA_W-1:0] fifo_wdata,
  input  logic              fifo_full,
  output logic              fifo_rd_req,
  input  logic [DATA_W-1:0] fifo_odata,
  input  logic              fifo_odata_valid,
  input  logic              fifo_empty,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              job_done,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic rr_ptr, inflight, wr_en, rd_act, push, pop, drained;
  logic [1:0] skid_cnt;
  logic [DATA_W-1:0] skid_head, skid_tail;
  assign wr_en = state == RUN && !fifo_full;
  assign req0_ready = wr_en && req0_valid && (!req1_valid || !rr_ptr);
  assign req1_ready = wr_en && req1_valid && (!req0_valid || rr_ptr);
  assign fifo_wr_req = req0_ready || req1_ready;
  assign fifo_wdata = req1_ready ? req1_data : req0_ready ? req0_data : '0;
  assign rd_act = state == RUN || state == DRAIN;
  assign push = fifo_odata_valid;
  assign out_valid = skid_cnt != 2'd0;
  assign out_data = skid_head;
  assign pop = out_valid && out_ready;
  // a pop in the same cycle frees a slot, which is what sustains one word per cycle
  assign fifo_rd_req = rd_act && !fifo_empty && ({1'b0, skid_cnt} + {2'b0, inflight} <= {2'b0, pop} + 3'd1);
  assign drained = fifo_empty && !inflight && skid_cnt == {1'b0, pop};
  assign busy = state != IDLE;
  assign job_done = state == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_compress) state_nxt = RUN;
      RUN:     if (data_terminal) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      inflight  <= 1'b0;
      skid_cnt  <= 2'd0;
      skid_head <= '0;
      skid_tail <= '0;
    end else begin
      state    <= state_nxt;
      if (fifo_wr_req) rr_ptr <= req0_ready;
      inflight <= fifo_rd_req || (inflight && !fifo_odata_valid);
      skid_cnt <= skid_cnt + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        skid_head <= (push && skid_cnt == 2'd1) ? fifo_odata : skid_tail;
        if (push) skid_tail <= fifo_odata;
      end else if (push) begin
        if (skid_cnt == 2'd0) skid_head <= fifo_odata;
        else skid_tail <= fifo_odata;
      end
    end
  end
`ifdef MATCH_SCHED_STATS_EN
  logic clr;
  assign clr = state == IDLE && start_compress;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (clr) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (fifo_wr_req && !(&wr_cnt)) wr_cnt <= wr_cnt + CNT_W'(1);
      if (pop && !(&rd_cnt)) rd_cnt <= rd_cnt + CNT_W'(1);
    end
  end
`else
  assign wr_cnt = '0;
  assign rd_cnt = '0;
`endif
endmodule

// File: tb/tb_match_fifo_sched.sv
// tb_match_fifo_sched: vector table, corner sequences and randomized jobs vs. a queue-based job model.
module tb_match_fifo_sched;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int IDLE = 0, RUN = 1, DRAIN = 2, DONE = 3;
`ifdef MATCH_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rstN = 1'b1;
  logic start_compress, data_terminal, req0_valid, req1_valid, req0_ready, req1_ready;
  logic [DW-1:0] req0_data, req1_data, fifo_wdata, fifo_odata, out_data;
  logic fifo_wr_req, fifo_full, fifo_rd_req, fifo_odata_valid, fifo_empty;
  logic out_valid, out_ready, busy, job_done;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic force_full = 1'b0;
  logic [DW-1:0] fq[$];
  int fcnt = 0, rd_total = 0, fifo_err = 0;

  match_fifo_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rstN(rstN), .start_compress(start_compress), .data_terminal(data_terminal),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .fifo_wr_req(fifo_wr_req), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_rd_req(fifo_rd_req), .fifo_odata(fifo_odata), .fifo_odata_valid(fifo_odata_valid),
    .fifo_empty(fifo_empty), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .job_done(job_done), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt));

  always #5 clk = ~clk;

  // 4Kx32 FIFO with one-cycle read latency
  assign fifo_full = force_full || fcnt >= 4096;
  assign fifo_empty = fcnt == 0;
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fq.delete();
      fcnt <= 0;
      fifo_odata <= '0;
      fifo_odata_valid <= 1'b0;
    end else begin
      fifo_odata_valid <= fifo_rd_req;
      if (fifo_rd_req) begin
        rd_total++;
        if (fq.size() == 0) fifo_err++;
        else fifo_odata <= fq.pop_front();
      end
      if (fifo_wr_req) begin
        if (fq.size() >= 4096) fifo_err++;
        fq.push_back(fifo_wdata);
      end
      fcnt <= fcnt + int'(fifo_wr_req) - int'(fifo_rd_req);
    end
  end

  int checks = 0, errors = 0, cyc = 0;
  int m_st = IDLE, m_wr = 0, m_rd = 0;
  bit m_rr = 1'b0;
  logic [DW-1:0] exp_q[$];
  int dseq[$], pcyc[$];
  int done_cnt = 0, done_cyc = 0, base;
  logic s_r0, s_r1, s_wr, s_ov, s_busy;

  typedef struct { logic r0, r1, full, g0, g1; } vec_t;
  vec_t tbl[10];
  int want_seq[6];

  function automatic int sat(input int v);
    return v > (1 << CW) - 1 ? (1 << CW) - 1 : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle_inputs();
    start_compress = 0; data_terminal = 0; req0_valid = 0; req1_valid = 0;
    req0_data = '0; req1_data = '0; out_ready = 0; force_full = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_fifo_wr_req"}, fifo_wr_req, 0);
    chk({tag, "_fifo_wdata"}, fifo_wdata, 0);
    chk({tag, "_fifo_rd_req"}, fifo_rd_req, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_job_done"}, job_done, 0);
    chk({tag, "_wr_cnt"}, wr_cnt, 0);
    chk({tag, "_rd_cnt"}, rd_cnt, 0);
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    idle_inputs();
    m_st = IDLE; m_rr = 1'b0; m_wr = 0; m_rd = 0;
    exp_q.delete();
    #1 chk_zero("rst");
    @(negedge clk) rstN = 1'b1;
    @(posedge clk) #1;
  endtask

  // one clock: check outputs against the job model at negedge, then advance the model
  task automatic tick();
    logic wr_ok, e0, e1;
    @(negedge clk);
    s_r0 = req0_ready; s_r1 = req1_ready; s_wr = fifo_wr_req; s_ov = out_valid; s_busy = busy;
    wr_ok = m_st == RUN && !fifo_full;
    e0 = wr_ok && req0_valid && (!req1_valid || !m_rr);
    e1 = wr_ok && req1_valid && (!req0_valid || m_rr);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("fifo_wr_req", fifo_wr_req, e0 | e1);
    if (e0 | e1) chk("fifo_wdata", fifo_wdata, e1 ? req1_data : req0_data);
    chk("busy", busy, m_st != IDLE);
    chk("job_done", job_done, m_st == DONE);
    chk("wr_cnt", wr_cnt, STATS ? sat(m_wr) : 0);
    chk("rd_cnt", rd_cnt, STATS ? sat(m_rd) : 0);
    if (req0_ready) dseq.push_back(0);
    if (req1_ready) dseq.push_back(1);
    if (job_done) begin done_cnt++; done_cyc = cyc; end
    if (out_valid) begin
      chk("out_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("out_data", out_data, exp_q[0]);
      if (out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        m_rd++;
        pcyc.push_back(cyc);
      end
    end
    if (e0) begin exp_q.push_back(req0_data); m_wr++; m_rr = 1'b1; end
    if (e1) begin exp_q.push_back(req1_data); m_wr++; m_rr = 1'b0; end
    case (m_st)
      IDLE:  if (start_compress) begin m_st = RUN; m_wr = 0; m_rd = 0; end
      RUN:   if (data_terminal) m_st = DRAIN;
      DRAIN: if (exp_q.size() == 0) m_st = DONE;
      default: m_st = IDLE;
    endcase
    @(posedge clk) #1;
    cyc++;
  endtask

  task automatic pulse_start();
    start_compress = 1; tick(); start_compress = 0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (m_st != IDLE && n < limit) begin tick(); n++; end
    chk("drain_timeout", m_st != IDLE, 0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    want_seq = '{0, 1, 0, 1, 0, 1};
    idle_inputs();
    #1 do_reset();

    // contention right after reset
    pulse_start();
    dseq.delete();
    out_ready = 1; req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 6; i++) begin
      req0_data = $urandom; req1_data = $urandom;
      tick();
    end
    chk("rr_grant_count", dseq.size(), 6);
    for (int i = 0; i < 6 && i < dseq.size(); i++) chk($sformatf("rr_grant_%0d", i), dseq[i], want_seq[i]);
    req0_valid = 0; req1_valid = 0;
    data_terminal = 1; tick(); data_terminal = 0;
    wait_done(100);

    // arbitration vector table
    do_reset();
    pulse_start();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      req0_valid = tbl[i].r0; req1_valid = tbl[i].r1; force_full = tbl[i].full;
      req0_data = 32'hA000_0000 + i; req1_data = 32'hB000_0000 + i;
      tick();
      chk($sformatf("tbl%0d_g0", i), s_r0, tbl[i].g0);
      chk($sformatf("tbl%0d_g1", i), s_r1, tbl[i].g1);
    end
    req0_valid = 0; req1_valid = 0; force_full = 0;
    data_terminal = 1; tick(); data_terminal = 0;
    wait_done(100);

    // single writer, full rate, done one cycle after last word
    do_reset();
    pulse_start();
    out_ready = 1; pcyc.delete(); done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1; req0_data = 32'h1000 + i; data_terminal = i == 7;
      tick();
    end
    req0_valid = 0; data_terminal = 0;
    wait_done(100);
    chk("single_words", pcyc.size(), 8);
    if (pcyc.size() == 8) begin
      chk("single_rate", pcyc[7] - pcyc[0], 7);
      chk("single_done_lat", done_cyc, pcyc[7] + 1);
    end
    chk("single_done_once", done_cnt, 1);
    chk("single_wr_cnt", wr_cnt, STATS ? 8 : 0);
    chk("single_rd_cnt", rd_cnt, STATS ? 8 : 0);

    // backpressure with five words queued
    do_reset();
    base = rd_total;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      req1_valid = 1; req1_data = 32'h2000 + i; tick();
    end
    req1_valid = 0;
    repeat (10) tick();
    chk("bp_reads_le2", rd_total - base <= 2, 1);
    chk("bp_fifo_level", fcnt, 3);
    chk("bp_out_valid", s_ov, 1);
    pcyc.delete();
    data_terminal = 1; tick(); data_terminal = 0;
    out_ready = 1;
    wait_done(100);
    chk("bp_delivered", pcyc.size(), 5);

    // asynchronous reset mid-RUN with a full skid buffer
    do_reset();
    base = rd_total;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1; req0_data = 32'h3000 + i; tick();
    end
    req0_valid = 0;
    repeat (6) tick();
    chk("mid_skid_reads", rd_total - base, 2);
    chk("mid_out_valid", s_ov, 1);
    do_reset();
    pulse_start();
    tick();
    chk("mid_restart_busy", s_busy, 1);
    data_terminal = 1; tick(); data_terminal = 0;
    wait_done(100);

    // FIFO full holds off the writer
    do_reset();
    pulse_start();
    force_full = 1; req0_valid = 1; req0_data = 32'h4000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("full_ready_%0d", i), s_r0, 0);
      chk($sformatf("full_wr_%0d", i), s_wr, 0);
    end
    force_full = 0;
    tick();
    chk("full_release", s_r0, 1);
    req0_valid = 0; out_ready = 1;
    data_terminal = 1; tick(); data_terminal = 0;
    wait_done(100);

    // terminal in the same cycle as a grant
    do_reset();
    pulse_start();
    out_ready = 1; pcyc.delete(); done_cnt = 0;
    req0_valid = 1; req0_data = 32'h5A5A_0001; data_terminal = 1;
    tick();
    chk("term_written", s_r0, 1);
    data_terminal = 0;
    for (int i = 0; i < 3; i++) begin
      req0_data = 32'h5A5A_0010 + i; tick();
      chk($sformatf("term_refused_%0d", i), s_r0, 0);
    end
    req0_valid = 0;
    wait_done(100);
    repeat (3) tick();
    chk("term_delivered", pcyc.size(), 1);
    chk("term_done_once", done_cnt, 1);
    if (pcyc.size() == 1) chk("term_done_after", done_cyc > pcyc[0], 1);

    // counter saturation
    do_reset();
    pulse_start();
    out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      req0_valid = 1; req0_data = $urandom; data_terminal = i == 19; tick();
    end
    req0_valid = 0; data_terminal = 0;
    wait_done(100);
    chk("sat_wr_cnt", wr_cnt, STATS ? (1 << CW) - 1 : 0);
    chk("sat_rd_cnt", rd_cnt, STATS ? (1 << CW) - 1 : 0);

    // randomized jobs with stray start/terminal pulses
    do_reset();
    for (int j = 0; j < 30; j++) begin
      int n, k;
      idle_inputs();
      repeat ($urandom_range(0, 2)) begin data_terminal = $urandom_range(0, 1) == 1; tick(); end
      data_terminal = 0;
      pulse_start();
      n = $urandom_range(5, 40);
      for (int i = 0; i < n; i++) begin
        req0_valid = $urandom_range(0, 9) < 6; req1_valid = $urandom_range(0, 9) < 6;
        req0_data = $urandom; req1_data = $urandom;
        force_full = $urandom_range(0, 6) == 0; out_ready = $urandom_range(0, 9) < 7;
        start_compress = $urandom_range(0, 7) == 0; data_terminal = i == n - 1;
        tick();
      end
      force_full = 0; start_compress = 0; data_terminal = 0;
      k = 0;
      while (m_st != IDLE && k < 300) begin
        req0_valid = $urandom_range(0, 1) == 1; req1_valid = $urandom_range(0, 1) == 1;
        out_ready = $urandom_range(0, 3) != 0;
        start_compress = $urandom_range(0, 7) == 0; data_terminal = $urandom_range(0, 7) == 0;
        tick(); k++;
      end
      chk($sformatf("rand_job%0d_timeout", j), m_st != IDLE, 0);
    end
    idle_inputs();
    tick();
    chk("fifo_protocol_errors", fifo_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
